serial_chunk_adder: RTL and testbench
=====================================

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 64, as the operand and result width in bits.
REQ-002 The block SHALL take parameter CHUNK, default 16, as the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK (N >= 1).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a new operation; sampled only in IDLE.
REQ-007 a  input  WIDTH  operand A; sampled on the accepting edge.
REQ-008 b  input  WIDTH  operand B; sampled on the accepting edge.
REQ-009 cin  input  1  carry-in; sampled on the accepting edge.
REQ-010 sub  input  1  mode: 0 = add, 1 = subtract; sampled on the accepting edge.
REQ-011 busy  output  1  high while slices are being computed.
REQ-012 done  output  1  one-cycle pulse; result outputs valid.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of bit WIDTH-1 (for subtract, 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 Transitions SHALL be: IDLE->RUN on start=1; RUN->DONE after the slice N-1 edge; DONE->IDLE unconditionally after one cycle.
REQ-018 On the accepting edge (IDLE, start=1), the block SHALL latch a, b_eff = sub ? ~b : b, and carry = cin XOR sub, and clear the slice counter to 0.
REQ-019 With sub=1, cin=0 the result SHALL be a-b; with sub=1, cin=1 it SHALL be a-b-1 (borrow-in).
REQ-020 In RUN, on each edge the block SHALL add slice k: bits [k*CHUNK +: CHUNK] of a and b_eff plus the stored carry, write the CHUNK-bit result into an internal result register, store the new carry, and increment k.
REQ-021 The slice counter SHALL be ceil(log2(N)) bits wide, minimum 1 bit, and SHALL NOT wrap during an operation.
REQ-022 After the edge that computes slice N-1, the block SHALL copy the internal result to sum, set cout to the final carry, and set ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-023 Latency SHALL be: acceptance at edge E0, slice k computed at edge E(k+1), done=1 during the cycle following edge EN, done=0 after edge E(N+1).
REQ-024 busy SHALL be 1 exactly in RUN (N cycles); done SHALL be 1 exactly in DONE (1 cycle); busy and done SHALL never be high together.
REQ-025 sum, cout and ovf SHALL change only on entry to DONE or on reset, and SHALL hold otherwise, including throughout the next RUN.
REQ-026 start SHALL be ignored in RUN and DONE; operand, cin and sub changes outside the accepting edge SHALL have no effect.
REQ-027 For N=1, RUN SHALL last one cycle and the behaviour SHALL be identical to the general case.

Reset
REQ-028 When rst=1 at an edge, the block SHALL enter IDLE and clear busy, done, sum, cout, ovf, the slice counter and the internal registers to 0.
REQ-029 rst SHALL take priority over start at the same edge.
REQ-030 A reset mid-operation SHALL abort the operation with no done pulse; a start on the first edge after rst deasserts SHALL be accepted.

Verification (WIDTH=64, CHUNK=16, N=4 unless stated)
REQ-031 Basic add: a=0x00aa, b=0x000f, cin=1, sub=0 -> sum=0xba, cout=0, ovf=0; busy high 4 cycles, then done high 1 cycle.
REQ-032 Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0.
REQ-033 Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-034 Subtract: a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; same case with cin=1 -> sum=0xFFFF_FFFF_FFFF_FFFD.
REQ-035 Mid-operation reset and ignored start:
- rst during the 2nd RUN cycle -> busy=0, no done pulse, sum=0.
- start held with new operands during RUN -> the first result is unaffected.
REQ-036 Parameter sweep: WIDTH=32/CHUNK=8 and WIDTH=16/CHUNK=16, 1000 random operations each, checked against a behavioural a+b_eff+carry model for sum, cout and ovf.

Source files
------------

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, rippling the carry
// between slices through a register. Results update only when an operation completes.
module serial_chunk_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic             carry_q;
  logic [CHUNK:0]   slice;
  logic             last;
  logic             msb_cin;

  // Operands shift right each slice so the active slice always sits in the low CHUNK bits;
  // results enter from the top so slice k lands at [k*CHUNK +: CHUNK] after N shifts.
  always_comb begin
    slice   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    res_d   = WIDTH'({slice[CHUNK-1:0], res_q} >> CHUNK);
    msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice[CHUNK-1];
    last    = (cnt_q == LastCnt);
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        busy = 1'b1;
        if (last) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          carry_q <= slice[CHUNK];
          res_q   <= res_d;
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          if (last) begin
            sum  <= res_d;
            cout <= slice[CHUNK];
            ovf  <= msb_cin ^ slice[CHUNK];
          end else begin
            // Counter holds at the last slice rather than wrapping.
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Drives three adder configurations (64/16, 32/8, 16/16) in lockstep from shared stimulus
// and compares each against an arithmetic reference model.
module tb_serial_chunk_adder;

  logic        clk = 1'b0;
  logic        rst, start, cin, sub;
  logic [63:0] a, b;

  logic [2:0]  busy, done, cout, ovf;
  logic [63:0] sum64;
  logic [31:0] sum32;
  logic [15:0] sum16;
  logic [63:0] osum [3];

  int checks = 0;
  int errors = 0;

  localparam int W [3]  = '{64, 32, 16};
  localparam int NS [3] = '{4, 4, 1};

  logic [63:0] prev_sum [3];
  logic        prev_c   [3];
  logic        prev_o   [3];

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(64), .CHUNK(16)) u_d64 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy[0]), .done(done[0]), .sum(sum64), .cout(cout[0]), .ovf(ovf[0])
  );

  serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_d32 (
    .clk(clk), .rst(rst), .start(start), .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
    .busy(busy[1]), .done(done[1]), .sum(sum32), .cout(cout[1]), .ovf(ovf[1])
  );

  serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_d16 (
    .clk(clk), .rst(rst), .start(start), .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .busy(busy[2]), .done(done[2]), .sum(sum16), .cout(cout[2]), .ovf(ovf[2])
  );

  always_comb begin
    osum[0] = sum64;
    osum[1] = {32'b0, sum32};
    osum[2] = {48'b0, sum16};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: w-bit two's-complement add of a, (sub ? ~b : b) and (cin ^ sub).
  function automatic logic [65:0] model(input int w, input logic [63:0] aa, input logic [63:0] bb,
                                        input logic ci, input logic sb);
    logic [63:0] mask, am, be, s;
    logic [64:0] tot;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = aa & mask;
    be   = (sb ? ~bb : bb) & mask;
    tot  = {1'b0, am} + {1'b0, be} + {64'd0, ci ^ sb};
    s    = tot[63:0] & mask;
    co   = tot[w];
    ov   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  task automatic run_op(input logic [63:0] aa, input logic [63:0] bb, input logic ci,
                        input logic sb, input bit hold);
    logic [65:0] exp [3];
    int          busy_cnt [3];
    int          done_cnt [3];
    int          done_at  [3];
    for (int d = 0; d < 3; d++) begin
      exp[d]      = model(W[d], aa, bb, ci, sb);
      busy_cnt[d] = 0;
      done_cnt[d] = 0;
      done_at[d]  = -1;
    end
    a = aa; b = bb; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 8; s++) begin
      for (int d = 0; d < 3; d++) begin
        if (busy[d]) busy_cnt[d]++;
        if (done[d]) begin
          done_cnt[d]++;
          if (done_at[d] < 0) begin
            done_at[d] = s;
            chk($sformatf("sum_w%0d", W[d]), osum[d], exp[d][63:0]);
            chk($sformatf("cout_w%0d", W[d]), {63'd0, cout[d]}, {63'd0, exp[d][64]});
            chk($sformatf("ovf_w%0d", W[d]), {63'd0, ovf[d]}, {63'd0, exp[d][65]});
          end
        end
        if (busy[d] && done[d]) chk($sformatf("busy_and_done_w%0d", W[d]), 64'd1, 64'd0);
        if (busy[d] && s == 0) begin
          chk($sformatf("hold_sum_w%0d", W[d]), osum[d], prev_sum[d]);
          chk($sformatf("hold_cout_w%0d", W[d]), {63'd0, cout[d]}, {63'd0, prev_c[d]});
          chk($sformatf("hold_ovf_w%0d", W[d]), {63'd0, ovf[d]}, {63'd0, prev_o[d]});
        end
      end
      // Scramble inputs after acceptance; optionally keep start high while every DUT is busy.
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cin = 1'($urandom); sub = 1'($urandom);
      start = (hold && s < 1) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("busy_cycles_w%0d", W[d]), 64'(busy_cnt[d]), 64'(NS[d]));
      chk($sformatf("done_at_w%0d", W[d]), 64'(done_at[d]), 64'(NS[d]));
      chk($sformatf("done_cycles_w%0d", W[d]), 64'(done_cnt[d]), 64'd1);
      prev_sum[d] = exp[d][63:0];
      prev_c[d]   = exp[d][64];
      prev_o[d]   = exp[d][65];
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      prev_sum[d] = '0; prev_c[d] = 1'b0; prev_o[d] = 1'b0;
    end
    // Reset with start asserted: reset must win.
    rst = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {61'd0, busy}, 64'd0);
    chk("rst_done", {61'd0, done}, 64'd0);
    chk("rst_sum64", sum64, 64'd0);
    chk("rst_cout_ovf", {58'd0, cout, ovf}, 64'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", {61'd0, busy}, 64'd0);

    run_op(64'h00aa, 64'h000f, 1'b1, 1'b0, 1'b0);
    chk("basic_sum", sum64, 64'hba);
    chk("basic_cout_ovf", {62'd0, cout[0], ovf[0]}, 64'd0);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0);
    chk("ripple_sum", sum64, 64'd0);
    chk("ripple_cout_ovf", {62'd0, cout[0], ovf[0]}, 64'd2);

    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
    chk("ovf_sum", sum64, 64'h8000_0000_0000_0000);
    chk("ovf_cout_ovf", {62'd0, cout[0], ovf[0]}, 64'd1);

    run_op(64'd5, 64'd7, 1'b0, 1'b1, 1'b0);
    chk("sub_sum", sum64, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_cout_ovf", {62'd0, cout[0], ovf[0]}, 64'd0);

    run_op(64'd5, 64'd7, 1'b1, 1'b1, 1'b0);
    chk("subb_sum", sum64, 64'hFFFF_FFFF_FFFF_FFFD);

    // Start held high with changing operands during the run.
    run_op(64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 1'b0, 1'b0, 1'b1);
    chk("held_start_sum", sum64, 64'h2222_2222_2222_2211);

    // Reset during the second RUN cycle aborts the operation.
    a = 64'h1111; b = 64'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {63'd0, busy[0]}, 64'd0);
    chk("abort_done", {63'd0, done[0]}, 64'd0);
    chk("abort_sum", sum64, 64'd0);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      prev_sum[d] = '0; prev_c[d] = 1'b0; prev_o[d] = 1'b0;
    end
    // Start on the first edge after reset release.
    run_op(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0, 1'b0, 1'b0);
    chk("post_rst_sum", sum64, 64'd7);

    for (int i = 0; i < 1000; i++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
